mux2_arbiter: RTL and testbench



---
 rtl/mux2_arbiter_pkg.sv | 20 ++
 rtl/mux2_arbiter_if.sv | 24 ++
 rtl/mux2_arbiter_hold_counter.sv | 40 ++++
 rtl/mux2_arbiter.sv | 120 ++++++++++++
 tb/tb_mux2_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux2_arbiter_pkg.sv
// rtl/mux2_arbiter_pkg.sv - shared state encodings, select constants and winner pick
// No ports. Holds the FSM state type, the mux select values and the arbitration helper.
package mux2_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;  // mux input a, requester 0
  localparam logic SEL_B = 1'b1;  // mux input b, requester 1

  // A tie goes to whichever requester was not the last owner; a lone
  // requester wins outright (req1 alone -> B, otherwise A).
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
    return (r0 && r1) ? ~last : r1;
  endfunction

endpackage

// File: rtl/mux2_arbiter_if.sv
// rtl/mux2_arbiter_if.sv - requester/mux-control bundle between the sources and the arbiter
// Signals: req0/req1 requests in; gnt0/gnt1 grants, sel mux select, en_ active-low
// mux enable and busy out of the arbiter.
interface mux2_arbiter_if;
  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic sel;
  logic en_;
  logic busy;

  // Requester / stimulus side.
  modport master (
    output req0, req1,
    input  gnt0, gnt1, sel, en_, busy
  );

  // Arbiter side.
  modport slave (
    input  req0, req1,
    output gnt0, gnt1, sel, en_, busy
  );
endinterface

// File: rtl/mux2_arbiter_hold_counter.sv
// rtl/mux2_arbiter_hold_counter.sv - saturating ownership-length counter with preemption flag
// Ports: clk, rst_ (async active-low), clr (zero the count), inc (count one GRANT cycle),
// term (count sits at MAXHOLD-1; never set when MAXHOLD is 0).
module mux2_arbiter_hold_counter #(
  parameter int MAXHOLD = 16,
  parameter int CNTW    = 5
) (
  input  logic clk,
  input  logic rst_,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam logic [CNTW-1:0] MAX_VAL  = CNTW'(MAXHOLD);
  localparam logic [CNTW-1:0] TERM_VAL = (MAXHOLD > 0) ? CNTW'(MAXHOLD - 1) : '0;
  localparam bit              PREEMPT  = (MAXHOLD > 0);

  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = PREEMPT && (cnt_q == TERM_VAL);

endmodule

// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - round-robin two-source arbiter driving a 74LS157-style mux
// Ports: clk, rst_ (async active-low), bus (slave modport: req0/req1 in;
// gnt0/gnt1, sel, en_, busy out). All outputs come straight from flops.
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int MAXHOLD = 16,
  parameter int CNTW    = 5
) (
  input  logic           clk,
  input  logic           rst_,
  mux2_arbiter_if.slave  bus
);

  state_t state_q, state_d;
  logic   sel_q,  sel_d;
  logic   en_n_q, en_n_d;
  logic   gnt0_q, gnt0_d;
  logic   gnt1_q, gnt1_d;
  logic   last_q, last_d;
  logic   cnt_clr, cnt_inc, hold_term;
  logic   own_req, oth_req;

  mux2_arbiter_hold_counter #(
    .MAXHOLD (MAXHOLD),
    .CNTW    (CNTW)
  ) u_hold (
    .clk  (clk),
    .rst_ (rst_),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .term (hold_term)
  );

  // sel always names the current candidate/owner from SETUP onward.
  assign own_req = (sel_q == SEL_B) ? bus.req1 : bus.req0;
  assign oth_req = (sel_q == SEL_B) ? bus.req0 : bus.req1;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_n_d  = en_n_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    last_d  = last_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          sel_d   = pick_winner(bus.req0, bus.req1, last_q);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (!own_req) begin
          state_d = ST_IDLE;  // requester gave up before its grant
        end else begin
          state_d = ST_GRANT;
          en_n_d  = 1'b0;
          gnt0_d  = (sel_q == SEL_A);
          gnt1_d  = (sel_q == SEL_B);
          last_d  = sel_q;
          cnt_clr = 1'b1;
        end
      end
      ST_GRANT: begin
        // Release outranks preemption; the waiter then goes via IDLE.
        if (!own_req) begin
          state_d = ST_IDLE;
          en_n_d  = 1'b1;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
        end else if (oth_req && hold_term) begin
          state_d = ST_SETUP;
          sel_d   = ~sel_q;  // safe: en_ goes high at this same edge
          en_n_d  = 1'b1;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_n_d  = 1'b1;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_A;
      en_n_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      last_q  <= SEL_B;  // requester 0 wins the first tie
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_n_q  <= en_n_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      last_q  <= last_d;
    end
  end

  assign bus.gnt0 = gnt0_q;
  assign bus.gnt1 = gnt1_q;
  assign bus.sel  = sel_q;
  assign bus.en_  = en_n_q;
  assign bus.busy = (state_q != ST_IDLE);

  a_gnt_excl: assert property (@(posedge clk) disable iff (!rst_) !(gnt0_q && gnt1_q));
  a_en_gnt:   assert property (@(posedge clk) disable iff (!rst_) (!en_n_q) == (gnt0_q || gnt1_q));

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - directed bench for mux2_arbiter with a behavioural 74LS157 on the output
// No ports. Drives two arbiters (MAXHOLD=4 and MAXHOLD=0) through directed sequences.
module tb_mux2_arbiter;

  localparam logic [7:0] A_DATA = 8'hA5;
  localparam logic [7:0] B_DATA = 8'h3C;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  mux2_arbiter_if bus4();
  mux2_arbiter_if bus0();

  mux2_arbiter #(.MAXHOLD(4), .CNTW(3)) u_dut4 (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus4.slave)
  );

  mux2_arbiter #(.MAXHOLD(0), .CNTW(5)) u_dut0 (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus0.slave)
  );

  // 74LS157: g_ high forces y low, s picks a or b.
  logic [7:0] y4, y0;
  assign y4 = bus4.en_ ? 8'h00 : (bus4.sel ? B_DATA : A_DATA);
  assign y0 = bus0.en_ ? 8'h00 : (bus0.sel ? B_DATA : A_DATA);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic inv_ok(input logic g0, input logic g1, input logic en_n,
                                  input logic sel, input logic sel_prev);
    return !(g0 && g1) && (en_n == !(g0 || g1)) && (!g1 || sel) && (!g0 || !sel)
           && ((sel == sel_prev) || en_n);
  endfunction

  logic mon_on = 1'b0;
  logic sel4_prev = 1'b0;
  logic sel0_prev = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      check("inv_dut4", inv_ok(bus4.gnt0, bus4.gnt1, bus4.en_, bus4.sel, sel4_prev), 1'b1);
      check("inv_dut0", inv_ok(bus0.gnt0, bus0.gnt1, bus0.en_, bus0.sel, sel0_prev), 1'b1);
    end
    sel4_prev = bus4.sel;
    sel0_prev = bus0.sel;
  end

  int g0cnt, g1cnt;

  initial begin
    rst_      = 1'b0;
    bus4.req0 = 1'b0;
    bus4.req1 = 1'b0;
    bus0.req0 = 1'b0;
    bus0.req1 = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_en", bus4.en_, 1'b1);
    check("rst_gnt", {bus4.gnt1, bus4.gnt0}, 2'b00);
    check("rst_sel", bus4.sel, 1'b0);
    check("rst_busy", bus4.busy, 1'b0);
    check("rst_dut0_en", bus0.en_, 1'b1);
    rst_   = 1'b1;
    mon_on = 1'b1;
    tick();

    // Tie right after reset: requester 0 first, then 1 after release
    bus4.req0 = 1'b1;
    bus4.req1 = 1'b1;
    tick();
    check("tie_setup_busy", bus4.busy, 1'b1);
    check("tie_setup_sel", bus4.sel, 1'b0);
    check("tie_setup_y", y4, 8'h00);
    tick();
    check("tie_gnt", {bus4.gnt1, bus4.gnt0}, 2'b01);
    check("tie_y_a", y4, A_DATA);
    bus4.req0 = 1'b0;
    tick();
    check("tie_rel_gnt", {bus4.gnt1, bus4.gnt0}, 2'b00);
    check("tie_rel_busy", bus4.busy, 1'b0);
    check("tie_rel_y", y4, 8'h00);
    tick();
    check("tie_setup1_sel", bus4.sel, 1'b1);
    check("tie_setup1_en", bus4.en_, 1'b1);
    tick();
    check("tie_gnt1", {bus4.gnt1, bus4.gnt0}, 2'b10);
    check("tie_y_b", y4, B_DATA);
    bus4.req1 = 1'b0;
    tick();
    check("tie_rel1_gnt1", bus4.gnt1, 1'b0);

    // Single requester, cycle 0 = req0 rise
    bus4.req0 = 1'b1;
    tick();  // cycle 1
    check("single_c1_busy", bus4.busy, 1'b1);
    check("single_c1_gnt0", bus4.gnt0, 1'b0);
    check("single_c1_y", y4, 8'h00);
    tick();  // cycle 2
    check("single_c2_gnt0", bus4.gnt0, 1'b1);
    check("single_c2_y", y4, A_DATA);
    repeat (4) tick();  // cycle 6
    check("single_c6_gnt0", bus4.gnt0, 1'b1);
    bus4.req0 = 1'b0;
    tick();  // cycle 7
    check("single_c7_gnt0", bus4.gnt0, 1'b0);
    check("single_c7_y", y4, 8'h00);

    // Preemption with MAXHOLD=4
    bus4.req0 = 1'b1;
    tick();  // SETUP
    tick();  // GRANT cycle 1
    check("pre_c1_gnt0", bus4.gnt0, 1'b1);
    tick();  // GRANT cycle 2
    bus4.req1 = 1'b1;
    tick();
    check("pre_c3_gnt0", bus4.gnt0, 1'b1);
    tick();
    check("pre_c4_gnt0", bus4.gnt0, 1'b1);
    tick();
    check("pre_setup_gnt", {bus4.gnt1, bus4.gnt0}, 2'b00);
    check("pre_setup_en", bus4.en_, 1'b1);
    check("pre_setup_sel", bus4.sel, 1'b1);
    check("pre_setup_busy", bus4.busy, 1'b1);
    tick();
    check("pre_gnt1", {bus4.gnt1, bus4.gnt0}, 2'b10);
    check("pre_y_b", y4, B_DATA);
    tick();
    check("pre_gnt1_c2", bus4.gnt1, 1'b1);
    bus4.req1 = 1'b0;
    tick();
    check("pre_rel_busy", bus4.busy, 1'b0);
    check("pre_rel_gnt1", bus4.gnt1, 1'b0);
    tick();
    check("pre_resetup_sel", bus4.sel, 1'b0);
    tick();
    check("pre_regrant0", bus4.gnt0, 1'b1);
    check("pre_regrant_y", y4, A_DATA);
    bus4.req0 = 1'b0;
    tick();

    // Abandoned request
    bus4.req1 = 1'b1;
    tick();
    check("aband_setup_sel", bus4.sel, 1'b1);
    check("aband_setup_en", bus4.en_, 1'b1);
    bus4.req1 = 1'b0;
    tick();
    check("aband_idle_busy", bus4.busy, 1'b0);
    check("aband_idle_gnt1", bus4.gnt1, 1'b0);
    tick();
    check("aband_en", bus4.en_, 1'b1);

    // Asynchronous reset mid-GRANT
    bus4.req1 = 1'b1;
    tick();
    tick();
    check("arst_pre_gnt1", bus4.gnt1, 1'b1);
    #2;
    rst_ = 1'b0;
    #1;
    check("arst_en", bus4.en_, 1'b1);
    check("arst_gnt", {bus4.gnt1, bus4.gnt0}, 2'b00);
    check("arst_sel", bus4.sel, 1'b0);
    check("arst_busy", bus4.busy, 1'b0);
    bus4.req1 = 1'b0;
    #1;
    rst_ = 1'b1;
    tick();

    // MAXHOLD=0: no preemption
    bus0.req0 = 1'b1;
    tick();  // SETUP
    bus0.req1 = 1'b1;
    tick();  // GRANT cycle 1
    g0cnt = 0;
    g1cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus0.gnt0) g0cnt++;
      if (bus0.gnt1) g1cnt++;
      tick();
    end
    check("nopre_gnt0_cycles", g0cnt, 100);
    check("nopre_gnt1_cycles", g1cnt, 0);
    bus0.req0 = 1'b0;
    tick();
    check("nopre_rel_gnt0", bus0.gnt0, 1'b0);
    tick();
    check("nopre_setup_sel", bus0.sel, 1'b1);
    tick();
    check("nopre_gnt1", bus0.gnt1, 1'b1);
    check("nopre_y_b", y0, B_DATA);
    bus0.req1 = 1'b0;
    tick();
    check("nopre_rel_gnt1", bus0.gnt1, 1'b0);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
